spi_target: RTL and testbench

SPI mode-0 target (slave) that receives bytes from an external SPI initiator and optionally returns bytes on MISO. It is the counterpart of the team's `spi` initiator. Its uses are loop-back verification of the OLED/frequency-counter SPI path and accepting configuration writes from an off-chip host. All SPI pins are asynchronous to `clk_in` and are oversampled.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_pin_sync.sv | 35 +++
 rtl/spi_target.sv | 151 +++++++++++++++
 tb/tb_spi_target.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and synchroniser depth for the SPI target.
package spi_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, plus rise/fall detection
// against a delayed copy of the final synchroniser stage.
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled receive path with optional MISO return path
// (tx logic present only when SPI_TARGET_MISO_EN is defined).
module spi_target
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  output logic [WIDTH-1:0] rx_data_out,
  output logic             rx_valid_out,
  input  logic [WIDTH-1:0] tx_data_in,
  output logic             tx_load_out,
  output logic             frame_active_out,
  output logic             abort_out,
  input  logic             select_in,
  input  logic             sck_in,
  input  logic             mosi_in,
  output logic             miso_out
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sel_rise, sel_fall, sel_sync_unused;
  logic sck_rise, sck_fall, sck_sync_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.RST_VAL(1'b1)) u_sel_sync (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .pin_i     (select_in),
    .sync_o    (sel_sync_unused),
    .rise_o    (sel_rise),
    .fall_o    (sel_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .pin_i     (sck_in),
    .sync_o    (sck_sync_unused),
    .rise_o    (sck_rise),
    .fall_o    (sck_fall)
  );

  // MOSI shares the same depth as SCK, so its stage-2 value is aligned with sck_rise.
  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .pin_i     (mosi_in),
    .sync_o    (mosi_sync),
    .rise_o    (mosi_rise_unused),
    .fall_o    (mosi_fall_unused)
  );

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             abort_q;
  logic [WIDTH-1:0] rx_next;

  assign rx_next = {rx_shift_q[WIDTH-2:0], mosi_sync};

`ifdef SPI_TARGET_MISO_EN
  logic [WIDTH-1:0] tx_shift_q;
  logic             tx_load_q;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
`ifdef SPI_TARGET_MISO_EN
      tx_shift_q <= '0;
      tx_load_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
`ifdef SPI_TARGET_MISO_EN
      tx_load_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (sel_fall) begin
            state_q   <= S_SHIFT;
            bit_cnt_q <= '0;
`ifdef SPI_TARGET_MISO_EN
            tx_load_q  <= 1'b1;
            tx_shift_q <= tx_data_in;
`endif
          end
        end
        S_SHIFT: begin
          // Select release outranks a coincident SCK edge; abort uses the pre-edge count.
          if (sel_rise) begin
            abort_q   <= (bit_cnt_q != '0);
            bit_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else if (sck_rise) begin
            rx_shift_q <= rx_next;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
`ifdef SPI_TARGET_MISO_EN
              tx_load_q  <= 1'b1;
              tx_shift_q <= tx_data_in;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
`ifdef SPI_TARGET_MISO_EN
            // A zero count means a fresh word was just loaded: keep its MSB on the line.
            if (bit_cnt_q != '0) begin
              tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
            end
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data_out      = rx_data_q;
  assign rx_valid_out     = rx_valid_q;
  assign abort_out        = abort_q;
  assign frame_active_out = (state_q == S_SHIFT);

`ifdef SPI_TARGET_MISO_EN
  assign tx_load_out = tx_load_q;
  assign miso_out    = (state_q == S_SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
`else
  logic [WIDTH-1:0] tx_data_unused;
  logic             sck_fall_unused;
  assign tx_data_unused  = tx_data_in;
  assign sck_fall_unused = sck_fall;
  assign tx_load_out     = 1'b0;
  assign miso_out        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed frames plus randomized multi-word
// frames, compared against a word-level model of the SPI transaction.
module tb_spi_target;

`ifdef SPI_TARGET_MISO_EN
  localparam bit MISO_EN = 1'b1;
`else
  localparam bit MISO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_load_out;
  logic       frame_active_out;
  logic       abort_out;
  logic       select_in = 1'b1;
  logic       sck_in = 1'b0;
  logic       mosi_in = 1'b0;
  logic       miso_out;

  int n_cmp = 0;
  int n_err = 0;

  int n_valid = 0;
  int n_load  = 0;
  int n_abort = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  spi_target #(.WIDTH(8)) dut (
    .clk_in          (clk),
    .reset_n_in      (rst_n),
    .rx_data_out     (rx_data_out),
    .rx_valid_out    (rx_valid_out),
    .tx_data_in      (tx_data_in),
    .tx_load_out     (tx_load_out),
    .frame_active_out(frame_active_out),
    .abort_out       (abort_out),
    .select_in       (select_in),
    .sck_in          (sck_in),
    .mosi_in         (mosi_in),
    .miso_out        (miso_out)
  );

  // Event monitor: sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_out) got_q.push_back(rx_data_out);
      n_valid += int'(rx_valid_out);
      n_load  += int'(tx_load_out);
      n_abort += int'(abort_out);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Initiator side of one word: MOSI set at SCK low, MISO sampled just before SCK rises.
  task automatic xfer_word(input logic [7:0] mw, input int nbits, input logic [7:0] tx_next,
                           output logic [7:0] mb);
    mb = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      mosi_in = mw[7-b];
      wait_clk(4);
      mb[7-b] = miso_out;
      sck_in = 1'b1;
      wait_clk(4);
      sck_in = 1'b0;
      if (b == 3) tx_data_in = tx_next;
    end
  endtask

  // Full frame: each MOSI word must arrive in order, each tx word must come back on MISO.
  task automatic frame(input string tag, input logic [7:0] mw[$], input logic [7:0] tw[$]);
    logic [7:0] mb;
    int v0, l0, a0, base, n;
    n    = mw.size();
    v0   = n_valid;
    l0   = n_load;
    a0   = n_abort;
    base = got_q.size();
    tx_data_in = tw[0];
    wait_clk(2);
    select_in = 1'b0;
    wait_clk(6);
    for (int i = 0; i < n; i++) begin
      xfer_word(mw[i], 8, (i + 1 < n) ? tw[i+1] : 8'($urandom), mb);
      check({tag, "_miso"}, 32'(mb), MISO_EN ? 32'(tw[i]) : 32'h0);
    end
    wait_clk(4);
    select_in = 1'b1;
    wait_clk(8);
    check({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'(n));
    check({tag, "_load_cnt"}, 32'(n_load - l0), MISO_EN ? 32'(n + 1) : 32'h0);
    check({tag, "_abort_cnt"}, 32'(n_abort - a0), 32'h0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rx_word"}, (base + i < got_q.size()) ? 32'(got_q[base+i]) : 32'hDEAD,
            32'(mw[i]));
    end
    check({tag, "_rx_hold"}, 32'(rx_data_out), 32'(mw[n-1]));
    check({tag, "_idle"}, 32'(frame_active_out), 32'h0);
  endtask

  initial begin
    logic [7:0] mq[$];
    logic [7:0] tq[$];
    logic [7:0] mb;
    logic       miso_seen;
    int v0, a0;

    // Reset held while pins toggle randomly.
    for (int i = 0; i < 24; i++) begin
      select_in = 1'($urandom);
      sck_in    = 1'($urandom);
      mosi_in   = 1'($urandom);
      wait_clk(1);
    end
    check("rst_rx_data", 32'(rx_data_out), 32'h0);
    check("rst_rx_valid", 32'(rx_valid_out), 32'h0);
    check("rst_tx_load", 32'(tx_load_out), 32'h0);
    check("rst_abort", 32'(abort_out), 32'h0);
    check("rst_frame_active", 32'(frame_active_out), 32'h0);
    check("rst_miso", 32'(miso_out), 32'h0);
    select_in = 1'b1;
    sck_in    = 1'b0;
    mosi_in   = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(20);
    check("post_rst_no_valid", 32'(n_valid), 32'h0);
    check("post_rst_idle", 32'(frame_active_out), 32'h0);

    // Single frame.
    mq = {8'hA5};
    tq = {8'h3C};
    frame("single", mq, tq);

    // Back-to-back words in one select window.
    mq = {8'h01, 8'hFF, 8'h80};
    tq = {8'h11, 8'h22, 8'h33};
    frame("b2b", mq, tq);

    // Select released after 5 bits: abort, partial word discarded.
    v0 = n_valid;
    a0 = n_abort;
    select_in = 1'b0;
    wait_clk(6);
    xfer_word(8'hF0, 5, 8'h00, mb);
    wait_clk(4);
    select_in = 1'b1;
    wait_clk(8);
    check("abort_cnt", 32'(n_abort - a0), 32'h1);
    check("abort_no_valid", 32'(n_valid - v0), 32'h0);
    check("abort_rx_hold", 32'(rx_data_out), 32'h80);
    mq = {8'h5A};
    tq = {8'h96};
    frame("after_abort", mq, tq);

    // SCK toggling with select deasserted is ignored.
    v0 = n_valid;
    miso_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mosi_in = 1'($urandom);
      sck_in  = 1'b1;
      wait_clk(4);
      miso_seen |= miso_out;
      sck_in = 1'b0;
      wait_clk(4);
      miso_seen |= miso_out | frame_active_out;
    end
    check("desel_no_valid", 32'(n_valid - v0), 32'h0);
    check("desel_miso_quiet", 32'(miso_seen), 32'h0);

    // Reset mid-word: outputs return to reset values immediately.
    tx_data_in = 8'hE7;
    select_in  = 1'b0;
    wait_clk(6);
    xfer_word(8'($urandom), 4, 8'h00, mb);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", 32'(rx_data_out), 32'h0);
    check("midrst_frame_active", 32'(frame_active_out), 32'h0);
    check("midrst_miso", 32'(miso_out), 32'h0);
    check("midrst_pulses", 32'({rx_valid_out, tx_load_out, abort_out}), 32'h0);
    wait_clk(2);
    select_in = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    mq = {8'hC3};
    tq = {8'h69};
    frame("after_rst", mq, tq);

    // Randomized multi-word frames.
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      mq = {};
      tq = {};
      for (int k = 0; k < nw; k++) begin
        mq.push_back(8'($urandom));
        tq.push_back(8'($urandom));
      end
      frame("rand", mq, tq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
